// File: rtl/cvt_wr_arb.sv
// Round-robin arbiter that funnels CVU write requests into one registered CVT write port.
// Build option CVT_ARB_STATS_EN adds a saturating count of issued writes on wr_count.
module cvt_wr_arb #(
    parameter int NREQ  = 4,
    parameter int GID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*5-1:0]    req_bb,
    input  logic [NREQ*10-1:0]   req_offset,
    input  logic [NREQ*64-1:0]   req_data,
    input  logic                 rd_active,
    output logic                 W_req,
    output logic [4:0]           WriteReg,
    output logic [9:0]           offset,
    output logic [63:0]          d_in,
    output logic [GID_W-1:0]     grant_id,
    output logic                 err_misalign,
    output logic [15:0]          wr_count
);

    // state  | meaning
    // IDLE   | no write registered, W_req low
    // ISSUE  | registered write presented, W_req high
    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GID_W-1:0]   r_rr;
    logic [4:0]         r_bb;
    logic [9:0]         r_off;
    logic [63:0]        r_data;
    logic [GID_W-1:0]   r_gid;
    logic               r_err;

    logic               w_found;
    logic [GID_W-1:0]   w_win;
    logic [GID_W:0]     w_sum;
    logic               w_accept;
    logic               w_issue;
    logic               w_misalign;
    logic [4:0]         w_bb;
    logic [9:0]         w_off;
    logic [63:0]        w_data;
    logic [GID_W-1:0]   w_rr_nxt;

    // first valid requester at or after r_rr, wrapping at NREQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr} + (GID_W+1)'(k);
            if (w_sum >= (GID_W+1)'(NREQ))
                w_sum = w_sum - (GID_W+1)'(NREQ);
            if (!w_found && req_valid[w_sum[GID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[GID_W-1:0];
            end
        end
    end

    assign w_accept   = rst && !rd_active && w_found;
    assign w_bb       = req_bb[5*int'(w_win) +: 5];
    assign w_off      = req_offset[10*int'(w_win) +: 10];
    assign w_data     = req_data[64*int'(w_win) +: 64];
    assign w_misalign = w_accept && (w_off[5:0] != 6'd0);
    assign w_issue    = w_accept && !w_misalign && (w_data != 64'd0);
    assign w_rr_nxt   = (w_win == GID_W'(NREQ-1)) ? '0 : w_win + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept)
            req_ready[w_win] = 1'b1;
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_issue)
            w_state_nxt = S_ISSUE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_bb    <= '0;
            r_off   <= '0;
            r_data  <= '0;
            r_gid   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_rr <= w_rr_nxt;
            // payload registers hold their last write while idle
            if (w_issue) begin
                r_bb   <= w_bb;
                r_off  <= w_off;
                r_data <= w_data;
                r_gid  <= w_win;
            end
            if (w_misalign)
                r_err <= 1'b1;
        end
    end

    assign W_req        = (r_state == S_ISSUE);
    assign WriteReg     = r_bb;
    assign offset       = r_off;
    assign d_in         = r_data;
    assign grant_id     = r_gid;
    assign err_misalign = r_err;

`ifdef CVT_ARB_STATS_EN
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (!rst)
            r_wr_count <= '0;
        else if (W_req && (r_wr_count != 16'hFFFF))
            r_wr_count <= r_wr_count + 16'd1;
    end

    assign wr_count = r_wr_count;
`else
    assign wr_count = 16'h0000;
`endif

endmodule
